// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select generation and load-use stall control for a 5-stage pipeline.
// Selects and bubble flag are registered with the EX slot; stall is combinational; stall_cnt saturates.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_alusrc,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic              ex_bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  // The WB slot is not held: the register file is write-through, so it never forwards.
  slot_t ex_slot;
  slot_t mem_slot;
  logic  ex_load;

  logic       load_hit;
  logic       issue;
  logic [1:0] fwd_a_nxt;
  logic [1:0] fwd_b_nxt;

  function automatic logic slot_writes(input slot_t s, input logic [REG_AW-1:0] r);
    return s.vld && s.regwrite && (s.rd == r) && (r != '0);
  endfunction

  function automatic logic [1:0] pick_sel(input logic use_r, input logic [REG_AW-1:0] r,
                                          input logic go, input slot_t ex_s, input slot_t mem_s);
    if (!go || !use_r || (r == '0)) return SEL_RF;
    if (slot_writes(ex_s, r))       return SEL_ALU;
    if (slot_writes(mem_s, r))      return SEL_WB;
    return SEL_RF;
  endfunction

  always_comb begin
    load_hit = ex_slot.vld && ex_load && ex_slot.regwrite && (ex_slot.rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_slot.rd)) ||
                (id_use_rs2 && !id_alusrc && (id_rs2 == ex_slot.rd)));
    // Reset also masks the hazard so a load caught in EX cannot stall during reset.
    stall     = !rst && id_valid && !flush && load_hit;
    issue     = id_valid && !stall && !flush;
    fwd_a_nxt = pick_sel(id_use_rs1, id_rs1, issue, ex_slot, mem_slot);
    fwd_b_nxt = id_alusrc ? SEL_IMM : pick_sel(id_use_rs2, id_rs2, issue, ex_slot, mem_slot);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot   <= '0;
      ex_load   <= 1'b0;
      mem_slot  <= '0;
      fwd_a     <= SEL_RF;
      fwd_b     <= SEL_RF;
      ex_bubble <= 1'b1;
      stall_cnt <= '0;
    end else begin
      mem_slot  <= ex_slot;
      ex_slot   <= issue ? '{vld: 1'b1, rd: id_rd, regwrite: id_regwrite} : '0;
      ex_load   <= issue && id_memread;
      fwd_a     <= fwd_a_nxt;
      fwd_b     <= fwd_b_nxt;
      ex_bubble <= !issue;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios plus random traffic against a history-based model.
module tb_fwd_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_use_rs1, id_use_rs2, id_alusrc, id_regwrite, id_memread, flush;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall, ex_bubble;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_alusrc(id_alusrc),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .ex_bubble(ex_bubble), .stall_cnt(stall_cnt)
  );

  // Model: the last two instructions (or bubbles) issued out of ID, newest first.
  typedef struct {bit vld; int rd; bit rw; bit ld;} rec_t;
  rec_t hist[$];
  int   m_cnt;
  bit   pre_stall;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic bit writes(input rec_t s, input int r);
    return s.vld && s.rw && (s.rd == r) && (r != 0);
  endfunction

  function automatic int pick(input bit use_r, input int r, input bit go);
    if (!go || !use_r || r == 0) return 0;
    if (writes(hist[0], r)) return 2;
    if (writes(hist[1], r)) return 1;
    return 0;
  endfunction

  task automatic reset_model();
    rec_t bub;
    bub = '{0, 0, 0, 0};
    hist = {bub, bub};
    m_cnt = 0;
  endtask

  task automatic step();
    rec_t e, n;
    bit   go, hit;
    int   ea, eb;
    #1;
    e   = hist[0];
    hit = e.vld && e.ld && e.rw && e.rd != 0 &&
          ((id_use_rs1 && int'(id_rs1) == e.rd) || (id_use_rs2 && !id_alusrc && int'(id_rs2) == e.rd));
    pre_stall = !rst && id_valid && !flush && hit;
    check("stall", int'(stall), int'(pre_stall));
    go = id_valid && !pre_stall && !flush;
    ea = pick(id_use_rs1, int'(id_rs1), go);
    eb = id_alusrc ? 3 : pick(id_use_rs2, int'(id_rs2), go);
    if (rst) begin
      reset_model();
      ea = 0; eb = 0; go = 0;
    end else begin
      n = go ? '{1, int'(id_rd), id_regwrite, id_memread} : '{0, 0, 0, 0};
      hist.push_front(n);
      void'(hist.pop_back());
      if (pre_stall && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    @(posedge clk);
    #1;
    check("fwd_a", int'(fwd_a), ea);
    check("fwd_b", int'(fwd_b), eb);
    check("ex_bubble", int'(ex_bubble), int'(!go));
    check("stall_cnt", int'(stall_cnt), m_cnt);
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input bit alu, input int rd, input bit rw, input bit ld);
    id_valid = v; id_rs1 = rs1[AW-1:0]; id_use_rs1 = u1; id_rs2 = rs2[AW-1:0];
    id_use_rs2 = u2; id_alusrc = alu; id_rd = rd[AW-1:0]; id_regwrite = rw; id_memread = ld;
  endtask

  task automatic op_alu(input int rd, input int rs1, input int rs2);
    drive(1, rs1, 1, rs2, 1, 0, rd, 1, 0);
  endtask

  task automatic op_lw(input int rd, input int rs1);
    drive(1, rs1, 1, 0, 0, 1, rd, 1, 1);
  endtask

  task automatic op_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_model();
    rst = 1'b1; flush = 1'b0;
    op_idle();
    step(); step();
    rst = 1'b0;
    check("reset_cnt", int'(stall_cnt), 0);
    check("reset_bubble", int'(ex_bubble), 1);

    // add x5 then add reading x5
    op_alu(5, 1, 2); step();
    op_alu(6, 5, 0); step();
    check("t1_fwd_a", int'(fwd_a), 2);
    check("t1_stall", int'(pre_stall), 0);

    // add x5, nop, sub reading x5 on rs2
    op_alu(5, 1, 2); step();
    op_idle(); step();
    op_alu(8, 3, 5); step();
    check("t2_fwd_b", int'(fwd_b), 1);

    // lw x7 then dependent add: one stall, then MEM forwarding
    op_lw(7, 1); step();
    op_alu(9, 7, 3); step();
    check("t3_stall", int'(pre_stall), 1);
    check("t3_bubble", int'(ex_bubble), 1);
    step();
    check("t3_fwd_a", int'(fwd_a), 1);
    check("t3_cnt", int'(stall_cnt), 1);

    // x0 never forwards; nearest stage wins
    op_alu(0, 1, 2); step();
    drive(1, 0, 1, 0, 0, 0, 3, 1, 0); step();
    check("t4_x0", int'(fwd_a), 0);
    op_alu(9, 1, 2); step();
    op_alu(9, 3, 4); step();
    op_alu(10, 9, 1); step();
    check("t4_near", int'(fwd_a), 2);

    // flush beats load-use; alusrc forces immediate select
    op_lw(7, 1); step();
    op_alu(11, 7, 2); flush = 1'b1; step();
    check("t5_stall", int'(pre_stall), 0);
    check("t5_bubble", int'(ex_bubble), 1);
    flush = 1'b0;
    drive(1, 3, 1, 0, 0, 1, 12, 1, 0); step();
    check("t5_imm", int'(fwd_b), 3);

    // saturate the counter
    for (int i = 0; i < 18; i++) begin
      op_lw(1, 2); step();
      op_alu(4, 1, 3); step(); step();
    end
    check("t6_sat", int'(stall_cnt), (1 << CW) - 1);

    // reset in the middle of a stall
    op_lw(1, 2); step();
    op_alu(4, 1, 3); rst = 1'b1; step();
    check("t6_rst_stall", int'(pre_stall), 0);
    check("t6_rst_fa", int'(fwd_a), 0);
    check("t6_rst_bub", int'(ex_bubble), 1);
    check("t6_rst_cnt", int'(stall_cnt), 0);
    rst = 1'b0; step();
    check("t6_post", int'(pre_stall), 0);

    // random traffic; a stalled instruction stays in ID
    for (int i = 0; i < 600; i++) begin
      if (!pre_stall) begin
        drive($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
              $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
